mem_stage_lsu: RTL

- Parametrised memory stage for the RISC-V pipeline.
- Sits between EX/MEM and WB.
- Functions:
  - Internal byte-addressable data memory with full RV32 load/store sizing: LB/LH/LW/LBU/LHU, SB/SH/SW.
  - Configurable memory wait-state latency, with a stall output to the hazard unit.
  - Branch resolution for all six RV32 branch conditions.
  - Registered MEM/WB outputs.

---
 rtl/mem_stage_lsu.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32 memory stage: load/store unit, wait states, branch resolution, MEM/WB register
//
// Purpose:
//   Sits between EX/MEM and WB. Holds a byte-addressable data memory,
//   inserts MEM_LATENCY wait cycles per load/store, resolves the six RV32
//   conditional branches and registers the result for writeback.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses suppress the store, clear
//               wb_reg_write and raise misaligned for that WB cycle.
//   undefined : low address bits are masked to natural alignment and
//               misaligned stays 0.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   valid_in                       instruction present at stage inputs
//   reg_write, mem_to_reg          control propagated to WB
//   mem_read, mem_write            load / store request
//   branch, zero_flag, lt_flag,
//   ltu_flag                       branch request and comparison flags
//   alu_out, rs2_data              effective address / ALU result, store data
//   funct3, rd                     access size / branch condition, dest reg
//   stall                          hold upstream stages (combinational)
//   pc_src                         branch taken (combinational)
//   wb_valid, wb_reg_write,
//   wb_mem_to_reg, wb_mem_data,
//   wb_alu_out, wb_rd, misaligned  registered MEM/WB outputs

module mem_stage_lsu #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int MEM_LATENCY = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic            reg_write,
  input  logic            mem_to_reg,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            branch,
  input  logic            zero_flag,
  input  logic            lt_flag,
  input  logic            ltu_flag,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd,
  output logic            stall,
  output logic            pc_src,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic            wb_mem_to_reg,
  output logic [XLEN-1:0] wb_mem_data,
  output logic [XLEN-1:0] wb_alu_out,
  output logic [4:0]      wb_rd,
  output logic            misaligned
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int LANES = XLEN / 8;
  // Counter preload; only meaningful when MEM_LATENCY > 0.
  localparam logic [3:0] LAT_M1 = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       mem_op;
  logic       retire;

  assign mem_op = valid_in & (mem_read | mem_write);

  // ---------------------------------------------------------------------------
  // Wait-state FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    stall        = 1'b0;
    retire       = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_op && (MEM_LATENCY > 0)) begin
          state_nxt    = S_WAIT;
          wait_cnt_nxt = LAT_M1;
          stall        = 1'b1;
        end else begin
          retire = 1'b1;
        end
      end
      S_WAIT: begin
        // Last wait cycle: stall drops and the held access completes.
        if (wait_cnt == 4'd0) begin
          state_nxt = S_IDLE;
          retire    = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
          stall        = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // While reset is held nothing is pending, so upstream must not be held.
    if (reset) begin
      stall  = 1'b0;
      retire = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode and alignment
  // ---------------------------------------------------------------------------
  logic [AW-1:0] word_idx;
  logic [1:0]    byte_off;
  logic          is_half;
  logic          is_word;
  logic          misalign_hit;
  logic          unused_addr_bits;

  assign word_idx         = alu_out[AW+1:2];
  assign byte_off         = alu_out[1:0];
  assign unused_addr_bits = ^alu_out[XLEN-1:AW+2];
  assign is_half          = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign is_word          = (funct3 == 3'b010);

`ifdef MISALIGN_TRAP_EN
  assign misalign_hit = mem_op & ((is_half & alu_out[0]) | (is_word & (|alu_out[1:0])));
`else
  // Half accesses only look at alu_out[1] and word accesses ignore [1:0],
  // which masks the offending bits to natural alignment.
  assign misalign_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Data memory
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  mem [DEPTH_WORDS];
  logic [LANES-1:0] byte_en;
  logic [XLEN-1:0]  wdata;
  logic             do_store;

  always_comb begin
    byte_en = '0;
    wdata   = '0;
    case (funct3)
      3'b000: begin
        byte_en[byte_off] = 1'b1;
        wdata             = {LANES{rs2_data[7:0]}};
      end
      3'b001: begin
        byte_en[{alu_out[1], 1'b0}] = 1'b1;
        byte_en[{alu_out[1], 1'b1}] = 1'b1;
        wdata                       = {(LANES/2){rs2_data[15:0]}};
      end
      3'b010: begin
        byte_en = '1;
        wdata   = rs2_data;
      end
      default: ;
    endcase
  end

  assign do_store = retire & valid_in & mem_write & ~misalign_hit;

  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < LANES; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  logic [XLEN-1:0] rword;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [XLEN-1:0] load_data;

  assign rword = mem[word_idx];
  assign rbyte = rword[{byte_off, 3'b000} +: 8];
  assign rhalf = rword[{alu_out[1], 4'b0000} +: 16];

  always_comb begin
    load_data = '0;
    case (funct3)
      3'b000:  load_data = {{(XLEN-8){rbyte[7]}}, rbyte};
      3'b001:  load_data = {{(XLEN-16){rhalf[15]}}, rhalf};
      3'b010:  load_data = rword;
      3'b100:  load_data = {{(XLEN-8){1'b0}}, rbyte};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, rhalf};
      default: load_data = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Branch resolution
  // ---------------------------------------------------------------------------
  logic br_cond;

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      3'b000:  br_cond = zero_flag;
      3'b001:  br_cond = ~zero_flag;
      3'b100:  br_cond = lt_flag;
      3'b101:  br_cond = ~lt_flag;
      3'b110:  br_cond = ltu_flag;
      3'b111:  br_cond = ~ltu_flag;
      default: br_cond = 1'b0;
    endcase
  end

  assign pc_src = valid_in & branch & br_cond;

  // ---------------------------------------------------------------------------
  // MEM/WB register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_mem_data   <= '0;
      wb_alu_out    <= '0;
      wb_rd         <= '0;
      misaligned    <= 1'b0;
    end else if (retire) begin
      wb_valid      <= valid_in;
      wb_reg_write  <= reg_write & ~misalign_hit;
      wb_mem_to_reg <= mem_to_reg;
      wb_mem_data   <= load_data;
      wb_alu_out    <= alu_out;
      wb_rd         <= rd;
      misaligned    <= misalign_hit;
    end else begin
      // Bubble into WB while the access is still waiting.
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      misaligned   <= 1'b0;
    end
  end

endmodule
